// File: rtl/db_chroma_ctrl.sv
// Chroma deblocking sequencer for one 16x16 tile (Cb and Cr).
// Scans 4-line edge segments, drives the buffer read/write ports and the filter control.
module db_chroma_ctrl #(
    parameter bit SKIP_TC0 = 1'b1,
    parameter int TC_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [15:0]     bs_v_i,
    input  logic [15:0]     bs_h_i,
    input  logic [TC_W-1:0] tc_cb_i,
    input  logic [TC_W-1:0] tc_cr_i,
    input  logic            hold_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            rd_en_o,
    output logic [4:0]      rd_addr_o,
    output logic            filt_vld_o,
    output logic [TC_W-1:0] filt_tc_o,
    output logic            filt_dir_o,
    output logic            wr_en_o,
    output logic [4:0]      wr_addr_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN_V = 3'd1,
        DRAIN  = 3'd2,
        SCAN_H = 3'd3,
        FLUSH  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state;
    logic [4:0]      ptr;         // {dir, comp, edge, seg[1:0]}
    logic [15:0]     bs_v_q;
    logic [15:0]     bs_h_q;
    logic [TC_W-1:0] tc_cb_q;
    logic [TC_W-1:0] tc_cr_q;

    // Two-stage pipeline: stage 1 = filter input valid, stage 2 = write-back.
    logic            vld1_q;
    logic [TC_W-1:0] tc1_q;
    logic            dir1_q;
    logic [4:0]      addr1_q;
    logic            vld2_q;
    logic [4:0]      addr2_q;

    logic [15:0]     bs_dir;
    logic [1:0]      seg_bs;
    logic [TC_W-1:0] seg_tc;
    logic            scanning;
    logic            filt_ok;
    logic            rd_fire;
    logic            advance;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        bs_dir   = ptr[4] ? bs_h_q : bs_v_q;
        seg_bs   = bs_dir[{ptr[2:0], 1'b0} +: 2];
        seg_tc   = ptr[3] ? tc_cr_q : tc_cb_q;
        scanning = (state == SCAN_V) || (state == SCAN_H);
        filt_ok  = (seg_bs == 2'd2) && !(SKIP_TC0 && (seg_tc == '0));
        rd_fire  = scanning && filt_ok && !hold_i;
        // Skipped segments are consumed even while the buffer port is busy.
        advance  = scanning && !(filt_ok && hold_i);
    end

    assign rd_en_o    = rd_fire;
    assign rd_addr_o  = rd_fire ? ptr : 5'd0;
    assign filt_vld_o = vld1_q;
    assign filt_tc_o  = tc1_q;
    assign filt_dir_o = dir1_q;
    assign wr_en_o    = vld2_q;
    assign wr_addr_o  = addr2_q;

    // NOTE: sequential state uses non-blocking assignments; the synchronous reset
    // clears every register, shadows included, so an aborted tile leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 5'd0;
            bs_v_q  <= 16'd0;
            bs_h_q  <= 16'd0;
            tc_cb_q <= '0;
            tc_cr_q <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            vld1_q  <= 1'b0;
            tc1_q   <= '0;
            dir1_q  <= 1'b0;
            addr1_q <= 5'd0;
            vld2_q  <= 1'b0;
            addr2_q <= 5'd0;
        end else begin
            vld1_q  <= rd_fire;
            tc1_q   <= rd_fire ? seg_tc : '0;
            dir1_q  <= rd_fire & ptr[4];
            addr1_q <= rd_fire ? ptr : 5'd0;
            vld2_q  <= vld1_q;
            addr2_q <= vld1_q ? addr1_q : 5'd0;
            done_o  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        bs_v_q  <= bs_v_i;
                        bs_h_q  <= bs_h_i;
                        tc_cb_q <= tc_cb_i;
                        tc_cr_q <= tc_cr_i;
                        ptr     <= 5'd0;
                        busy_o  <= 1'b1;
                        state   <= SCAN_V;
                    end
                end
                SCAN_V: begin
                    if (advance) begin
                        ptr <= ptr + 5'd1;
                        if (ptr == 5'd15) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The write stage retires on this same edge, so an empty filter
                    // stage is enough to place the first H read after the last V write.
                    if (!vld1_q) state <= SCAN_H;
                end
                SCAN_H: begin
                    if (advance) begin
                        ptr <= ptr + 5'd1;
                        if (ptr == 5'd31) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!vld1_q) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_db_chroma_ctrl.sv
// Directed bench for db_chroma_ctrl: logs every rd/filter/wr strobe of a tile
// run and compares it against hand-derived cycle/address tables.
module tb_db_chroma_ctrl;

    localparam int TC_W = 5;
    localparam int NO_RST = 1000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [15:0]     bs_v_i;
    logic [15:0]     bs_h_i;
    logic [TC_W-1:0] tc_cb_i;
    logic [TC_W-1:0] tc_cr_i;
    logic            hold_i;
    logic            busy_o;
    logic            done_o;
    logic            rd_en_o;
    logic [4:0]      rd_addr_o;
    logic            filt_vld_o;
    logic [TC_W-1:0] filt_tc_o;
    logic            filt_dir_o;
    logic            wr_en_o;
    logic [4:0]      wr_addr_o;

    always #5 clk = ~clk;

    db_chroma_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .bs_v_i     (bs_v_i),
        .bs_h_i     (bs_h_i),
        .tc_cb_i    (tc_cb_i),
        .tc_cr_i    (tc_cr_i),
        .hold_i     (hold_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_en_o    (rd_en_o),
        .rd_addr_o  (rd_addr_o),
        .filt_vld_o (filt_vld_o),
        .filt_tc_o  (filt_tc_o),
        .filt_dir_o (filt_dir_o),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o)
    );

    int n_vec  = 0;
    int n_miss = 0;

    int rd_cyc[$], rd_adr[$], wr_cyc[$], wr_adr[$];
    int ft_cyc[$], ft_tc[$], ft_dir[$];
    int ex_cyc[$], ex_adr[$], ex_tc[$];
    int done_cnt, done_cyc, idle_bad, snap;
    logic busy_log [64];

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int out_snapshot();
        return int'({busy_o, done_o, rd_en_o, rd_addr_o, filt_vld_o,
                     filt_tc_o, filt_dir_o, wr_en_o, wr_addr_o});
    endfunction

    // Runs one tile with start at cycle 0; cycles are numbered from the start cycle.
    task automatic run_tile(input logic [15:0] bsv, input logic [15:0] bsh,
                            input logic [TC_W-1:0] tcb, input logic [TC_W-1:0] tcr,
                            input int hold_at, input int hold_len,
                            input int restart_at, input int rst_at);
        rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
        ft_cyc.delete(); ft_tc.delete(); ft_dir.delete();
        done_cnt = 0; done_cyc = -1; idle_bad = 0; snap = -1;
        bs_v_i = bsv; bs_h_i = bsh; tc_cb_i = tcb; tc_cr_i = tcr;
        for (int c = 0; c < 60; c++) begin
            start_i = (c == 0) || (c == restart_at);
            hold_i  = (hold_len > 0) && (c >= hold_at) && (c < hold_at + hold_len);
            rst     = (c == rst_at);
            if (c == restart_at) begin
                bs_v_i  = ~bsv;
                bs_h_i  = 16'h5555;
                tc_cb_i = ~tcb;
                tc_cr_i = ~tcr;
            end
            @(negedge clk);
            busy_log[c] = busy_o;
            if (rd_en_o) begin rd_cyc.push_back(c); rd_adr.push_back(int'(rd_addr_o)); end
            if (wr_en_o) begin wr_cyc.push_back(c); wr_adr.push_back(int'(wr_addr_o)); end
            if (filt_vld_o) begin
                ft_cyc.push_back(c); ft_tc.push_back(int'(filt_tc_o)); ft_dir.push_back(int'(filt_dir_o));
            end else if (filt_tc_o != '0 || filt_dir_o) begin
                idle_bad++;
            end
            if (done_o) begin done_cnt++; done_cyc = c; end
            if (c == rst_at + 1) snap = out_snapshot();
            @(posedge clk); #1;
        end
        start_i = 1'b0; hold_i = 1'b0; rst = 1'b0;
    endtask

    task automatic add_exp(input int cyc, input int adr, input int tc);
        ex_cyc.push_back(cyc); ex_adr.push_back(adr); ex_tc.push_back(tc);
    endtask

    // Reads must match the table; filter and write entries follow each read by 1 and 2 cycles.
    task automatic compare(input string tag, input int lim);
        int nf = 0;
        int nw = 0;
        check({tag, " rd count"}, rd_cyc.size(), ex_cyc.size());
        foreach (ex_cyc[i]) begin
            if (i < rd_cyc.size()) begin
                check($sformatf("%s rd%0d cyc", tag, i), rd_cyc[i], ex_cyc[i]);
                check($sformatf("%s rd%0d adr", tag, i), rd_adr[i], ex_adr[i]);
            end
            if (ex_cyc[i] + 1 <= lim) begin
                if (nf < ft_cyc.size()) begin
                    check($sformatf("%s ft%0d cyc", tag, i), ft_cyc[nf], ex_cyc[i] + 1);
                    check($sformatf("%s ft%0d tc", tag, i), ft_tc[nf], ex_tc[i]);
                    check($sformatf("%s ft%0d dir", tag, i), ft_dir[nf], (ex_adr[i] >> 4) & 1);
                end
                nf++;
            end
            if (ex_cyc[i] + 2 <= lim) begin
                if (nw < wr_cyc.size()) begin
                    check($sformatf("%s wr%0d cyc", tag, i), wr_cyc[nw], ex_cyc[i] + 2);
                    check($sformatf("%s wr%0d adr", tag, i), wr_adr[nw], ex_adr[i]);
                end
                nw++;
            end
        end
        check({tag, " ft count"}, ft_cyc.size(), nf);
        check({tag, " wr count"}, wr_cyc.size(), nw);
        check({tag, " idle filt zero"}, idle_bad, 0);
    endtask

    // Full tile, all bs = 2, tc 5/7: V reads T1..T16, H reads T19..T34.
    task automatic exp_full();
        ex_cyc.delete(); ex_adr.delete(); ex_tc.delete();
        for (int i = 0; i < 32; i++)
            add_exp((i < 16) ? 1 + i : 3 + i, i, ((i >> 3) & 1) ? 7 : 5);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; hold_i = 1'b0;
        bs_v_i = 16'hFFFF; bs_h_i = 16'hFFFF; tc_cb_i = 5'd9; tc_cr_i = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", out_snapshot(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: nominal tile
        run_tile(16'hAAAA, 16'hAAAA, 5'd5, 5'd7, 0, 0, -1, -1);
        exp_full();
        compare("full", NO_RST);
        check("full done cyc", done_cyc, 37);
        check("full done cnt", done_cnt, 1);
        check("full busy T0", int'(busy_log[0]), 0);
        check("full busy T1", int'(busy_log[1]), 1);
        check("full busy T37", int'(busy_log[37]), 1);
        check("full busy T38", int'(busy_log[38]), 0);

        // 2: no vertical filtering, DRAIN lasts one cycle
        run_tile(16'h0000, 16'hAAAA, 5'd3, 5'd3, 0, 0, -1, -1);
        ex_cyc.delete(); ex_adr.delete(); ex_tc.delete();
        for (int i = 0; i < 16; i++) add_exp(18 + i, 16 + i, 3);
        compare("honly", NO_RST);
        check("honly done cyc", done_cyc, 36);

        // 3: Cb tc = 0 is skipped entirely
        run_tile(16'hAAAA, 16'hAAAA, 5'd0, 5'd4, 0, 0, -1, -1);
        ex_cyc.delete(); ex_adr.delete(); ex_tc.delete();
        for (int i = 0; i < 8; i++) add_exp(9 + i, 8 + i, 4);
        for (int i = 8; i < 16; i++) add_exp(19 + i, 16 + i, 4);
        compare("skip", NO_RST);
        check("skip done cyc", done_cyc, 37);

        // 4: hold for T5..T7 freezes the pointer at segment 4
        run_tile(16'hAAAA, 16'hAAAA, 5'd5, 5'd7, 5, 3, -1, -1);
        ex_cyc.delete(); ex_adr.delete(); ex_tc.delete();
        for (int i = 0; i < 32; i++)
            add_exp((i < 4) ? 1 + i : (i < 16) ? 4 + i : 6 + i, i, ((i >> 3) & 1) ? 7 : 5);
        compare("hold", NO_RST);
        check("hold done cyc", done_cyc, 40);

        // 5: reset in SCAN_H at T25 aborts the tile
        run_tile(16'hAAAA, 16'hAAAA, 5'd5, 5'd7, 0, 0, -1, 25);
        exp_full();
        while (ex_cyc.size() > 23) begin
            void'(ex_cyc.pop_back()); void'(ex_adr.pop_back()); void'(ex_tc.pop_back());
        end
        compare("abort", 25);
        check("abort outputs", snap, 0);
        check("abort done cnt", done_cnt, 0);
        check("abort busy T27", int'(busy_log[27]), 0);

        run_tile(16'hAAAA, 16'hAAAA, 5'd5, 5'd7, 0, 0, -1, -1);
        exp_full();
        compare("rerun", NO_RST);
        check("rerun done cyc", done_cyc, 37);

        // 6: start while busy, with different inputs presented, is ignored
        run_tile(16'hAAAA, 16'hAAAA, 5'd5, 5'd7, 0, 0, 10, -1);
        exp_full();
        compare("restart", NO_RST);
        check("restart done cyc", done_cyc, 37);
        check("restart done cnt", done_cnt, 1);

        // 7: start coinciding with done_o is ignored
        run_tile(16'h0000, 16'hAAAA, 5'd3, 5'd3, 0, 0, 36, -1);
        ex_cyc.delete(); ex_adr.delete(); ex_tc.delete();
        for (int i = 0; i < 16; i++) add_exp(18 + i, 16 + i, 3);
        compare("startdone", NO_RST);
        check("startdone done cyc", done_cyc, 36);
        check("startdone busy T37", int'(busy_log[37]), 0);
        check("startdone busy T38", int'(busy_log[38]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
